// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: valid/ready single-transfer commands in, one in-order response pulse per command out.
// Latency 2 edges accept->rsp plus one per HREADY-low cycle; HREADY low freezes both stages and drops cmd_ready.
module ahb_lite_cmd_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    // address stage
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        a_vld_q, a_vld_d;
    logic        a_lerr_q, a_lerr_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    // data stage
    logic        d_vld_q, d_vld_d;
    logic        d_lerr_q, d_lerr_d;
    logic        d_write_q, d_write_d;
    logic [1:0]  d_lane_q, d_lane_d;
    logic [2:0]  d_size_q, d_size_d;
    logic [31:0] hwdata_q, hwdata_d;

    // response
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        cmd_fire;
    logic        cmd_illegal;
    logic [31:0] cmd_wdata_rep;
    logic [31:0] rd_shift;
    logic [31:0] rd_lane;

    assign cmd_ready = HRESETn & HREADY;
    assign cmd_fire  = cmd_valid & cmd_ready;

    always_comb begin
        cmd_illegal   = 1'b0;
        cmd_wdata_rep = cmd_wdata;
        case (cmd_size)
            3'd0: begin
                cmd_illegal   = 1'b0;
                cmd_wdata_rep = {4{cmd_wdata[7:0]}};
            end
            3'd1: begin
                cmd_illegal   = cmd_addr[0];
                cmd_wdata_rep = {2{cmd_wdata[15:0]}};
            end
            3'd2: begin
                cmd_illegal   = |cmd_addr[1:0];
                cmd_wdata_rep = cmd_wdata;
            end
            default: begin
                cmd_illegal   = 1'b1;
                cmd_wdata_rep = cmd_wdata;
            end
        endcase
    end

    // Slave drives the full word; pick out the addressed lane and zero-extend.
    assign rd_shift = HRDATA >> {d_lane_q, 3'b000};

    always_comb begin
        rd_lane = rd_shift;
        case (d_size_q)
            3'd0:    rd_lane = {24'h0, rd_shift[7:0]};
            3'd1:    rd_lane = {16'h0, rd_shift[15:0]};
            default: rd_lane = rd_shift;
        endcase
    end

    always_comb begin
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        a_vld_d     = a_vld_q;
        a_lerr_d    = a_lerr_q;
        a_wdata_d   = a_wdata_q;
        d_vld_d     = d_vld_q;
        d_lerr_d    = d_lerr_q;
        d_write_d   = d_write_q;
        d_lane_d    = d_lane_q;
        d_size_d    = d_size_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        if (HREADY) begin
            if (cmd_fire) begin
                haddr_d   = cmd_addr;
                hwrite_d  = cmd_write;
                hsize_d   = cmd_size;
                // Illegal commands occupy a pipeline slot but never reach the bus.
                htrans_d  = cmd_illegal ? TR_IDLE : TR_NONSEQ;
                a_vld_d   = 1'b1;
                a_lerr_d  = cmd_illegal;
                a_wdata_d = cmd_wdata_rep;
            end else begin
                htrans_d  = TR_IDLE;
                a_vld_d   = 1'b0;
                a_lerr_d  = 1'b0;
            end

            d_vld_d   = a_vld_q;
            d_lerr_d  = a_lerr_q;
            d_write_d = hwrite_q;
            d_lane_d  = haddr_q[1:0];
            d_size_d  = hsize_q;
            hwdata_d  = a_wdata_q;

            if (d_vld_q) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = d_lerr_q | HRESP;
                rsp_rdata_d = (d_write_q || d_lerr_q || HRESP) ? 32'h0 : rd_lane;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q     <= 32'h0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            a_vld_q     <= 1'b0;
            a_lerr_q    <= 1'b0;
            a_wdata_q   <= 32'h0;
            d_vld_q     <= 1'b0;
            d_lerr_q    <= 1'b0;
            d_write_q   <= 1'b0;
            d_lane_q    <= 2'd0;
            d_size_q    <= 3'd0;
            hwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            a_vld_q     <= a_vld_d;
            a_lerr_q    <= a_lerr_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_lerr_q    <= d_lerr_d;
            d_write_q   <= d_write_d;
            d_lane_q    <= d_lane_d;
            d_size_q    <= d_size_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HSEL      = (htrans_q == TR_NONSEQ);
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = a_vld_q | d_vld_q | rsp_valid_q;

endmodule

// File: doc/ahb_lite_cmd_master.md
# ahb_lite_cmd_master

AHB-Lite initiator for the user project's AHB slave port (HCLK/HRESETn/HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY → HRDATA/HREADYOUT). It converts a valid/ready command stream of single transfers into pipelined AHB-Lite NONSEQ transfers. It returns one in-order response per command. It serves as the bench-side and in-SoC driver for the user register space, with lane replication, read extraction and local alignment checking.

## Interface
- No parameters. Address and data are fixed at 32 bits.
- HCLK  in  1  bus clock; everything is rising-edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on the edge where valid&ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  0 = byte, 1 = half, 2 = word; values 3-7 are illegal.
- cmd_wdata  in  32  write data, LSB-justified.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata  out  32  read data, LSB-justified and zero-extended; 0 for writes and errors.
- rsp_err  out  1  HRESP error or local alignment error.
- busy  out  1  at least one command is accepted but not yet responded.
- HSEL  out  1  slave select; equals (HTRANS==NONSEQ).
- HADDR  out  32  address-phase address.
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HWRITE  out  1  address-phase direction.
- HSIZE  out  3  address-phase size.
- HWDATA  out  32  data-phase write data.
- HREADY  in  1  slave HREADYOUT, fed back.
- HRDATA  in  32  slave read data.
- HRESP  in  1  slave error response.

## Operation
- The block is a two-stage pipeline:
  - **A (address phase):** holds the registered HADDR, HTRANS, HWRITE and HSIZE, plus flags a_vld and a_lerr.
  - **D (data phase):** holds d_vld, d_lerr, d_write, d_lane = HADDR[1:0], d_size, and HWDATA.
- `cmd_ready = HRESETn & HREADY`. Both stages advance only on an edge with HREADY=1. When HREADY=0, all A and D registers hold, so NONSEQ and its controls stay stable per the AHB rule.
- Advance when HREADY=1:
  - **A loads from the command:** done when cmd_valid&cmd_ready.
    - Aligned legal command: HTRANS=NONSEQ, a_vld=1, a_lerr=0.
    - Illegal command (size>2, or addr not aligned to 1<<size): HTRANS=IDLE, a_vld=1, a_lerr=1. HADDR/HWRITE/HSIZE still load, but the bus sees IDLE.
  - **A with no command:** HTRANS=IDLE, a_vld=0, and HADDR/HWRITE/HSIZE hold their previous values.
  - **D loads from A:** D takes a_vld, a_lerr, HWRITE, HADDR[1:0] and HSIZE.
  - **HWDATA lane replication:** byte gives {4{wdata[7:0]}}, half gives {2{wdata[15:0]}}, word gives wdata. The captured command write data travels with A into D.
- Completion: on an edge with HREADY=1 and d_vld=1, the next cycle carries rsp_valid=1 and the response fields:
  - rsp_err = d_lerr | HRESP.
  - rsp_rdata = 0 for writes, errors, and local errors.
  - Otherwise rsp_rdata = HRDATA shifted right by 8*d_lane, masked to 8/16/32 bits by d_size.
- Error response: the two-cycle HRESP sequence is HREADY=0/HRESP=1, then HREADY=1/HRESP=1. HRESP is sampled only on the completing edge. A pending NONSEQ in A is not cancelled; it proceeds normally.
- Responses are strictly in command order. Local errors travel through the pipeline so that ordering is preserved.
- busy = a_vld | d_vld | rsp_valid.

## Timing
- Reset values (asynchronous clear):
  - HTRANS=IDLE; HSEL=0; HADDR, HWRITE, HSIZE, HWDATA all 0.
  - a_vld, d_vld, rsp_valid, rsp_err = 0; rsp_rdata=0; busy=0; cmd_ready=0.
- Latency with no wait states: command accepted at edge N → NONSEQ in cycle N..N+1 → data phase N+1..N+2 → rsp_valid high in cycle N+2..N+3. That is 2 edges plus one cycle per HREADY-low cycle.
- Throughput: one command per cycle with zero wait states.
- HREADY=0 stalls both stages and drops cmd_ready in the same cycle (combinational path).
- Reset asserted mid-operation clears everything immediately. In-flight commands produce no response, and no NONSEQ is driven after the reset edge.

## Test plan
- **Word write:** write 0x3000_0004 ← 0xDEADBEEF, HREADY=1.
  - NONSEQ with HADDR=0x3000_0004, HSIZE=2 one cycle after accept; HWDATA=0xDEADBEEF the next cycle.
  - rsp_valid 2 edges after accept, err=0, rdata=0.
- **Byte read:** read 0x3000_0003, size 0, HRDATA=0x11223344.
  - rsp_rdata=0x00000011.
  - A half read at 0x...2 returns 0x00001122.
- **Wait states:** same read with HREADY low for 3 cycles during the data phase.
  - HTRANS/HADDR of the next queued command stay stable.
  - rsp arrives 3 cycles later.
  - cmd_ready=0 during the stall.
- **Back-to-back mix:** 4 commands (W, R, illegal size=2 at addr 0x...2, R) with cmd_valid held.
  - Four consecutive rsp pulses, in order.
  - The third has err=1 and rdata=0, and the bus shows IDLE in its address slot.
- **Slave error:** two-cycle HRESP error on a write with the next read pending in A.
  - Write rsp_err=1.
  - The pending read still issues and completes with err=0.
- **Reset mid-operation:** pull HRESETn low while a read is in the data phase with HREADY=0.
  - All outputs at reset values immediately.
  - No rsp_valid after release until a new command.
